// File: rtl/jtag_tx_arbiter_if.sv
// Handshake bundle between the JTAG POP arbiter, its requesters and the capture logic.
interface jtag_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 28
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               cap;
  logic [31:0]        tx_word;
  logic               busy;

  modport master (
    output req_valid, req_data, cap,
    input  req_ready, tx_word, busy
  );

  modport slave (
    input  req_valid, req_data, cap,
    output req_ready, tx_word, busy
  );
endinterface

// File: rtl/jtag_tx_arbiter.sv
// Round-robin arbiter sharing the 32-bit JTAG POP word among NREQ requesters.
// Optional capture statistics counters are built when JTAG_ARB_STATS_EN is defined.
module jtag_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 28
) (
  input  logic               clk,
  input  logic               reset,
  jtag_tx_arbiter_if.slave   bus
`ifdef JTAG_ARB_STATS_EN
  ,
  output logic [15:0]        pop_count,
  output logic [15:0]        empty_count
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [31:0]     tx_word_q, tx_word_d;
  logic            found;
  logic [2:0]      winner;
  logic [DW-1:0]   payload;
  logic [NREQ-1:0] gnt;

  // Two passes: indices at or above ptr first, then the wrapped-around low indices.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    payload = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid[i] && (3'(i) >= ptr_q)) begin
        found   = 1'b1;
        winner  = 3'(i);
        payload = bus.req_data[i*DW +: DW];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid[i]) begin
        found   = 1'b1;
        winner  = 3'(i);
        payload = bus.req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = !reset && (state_q == S_IDLE) && found && (winner == 3'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tx_word_d = tx_word_q;
    if (state_q == S_IDLE) begin
      if (found) begin
        state_d   = S_HOLD;
        ptr_d     = (winner == 3'(NREQ-1)) ? 3'd0 : winner + 3'd1;
        tx_word_d = {1'b1, winner, payload};
      end
    end else if (bus.cap) begin
      state_d   = S_IDLE;
      tx_word_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      tx_word_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tx_word_q <= tx_word_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.tx_word   = tx_word_q;
  assign bus.busy      = (state_q == S_HOLD);

`ifdef JTAG_ARB_STATS_EN
  logic [15:0] pop_count_q, empty_count_q;

  // Saturating counters of host captures that found a word vs. an empty slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_count_q   <= '0;
      empty_count_q <= '0;
    end else if (bus.cap) begin
      if (state_q == S_HOLD) begin
        if (pop_count_q != 16'hFFFF) pop_count_q <= pop_count_q + 16'd1;
      end else begin
        if (empty_count_q != 16'hFFFF) empty_count_q <= empty_count_q + 16'd1;
      end
    end
  end

  assign pop_count   = pop_count_q;
  assign empty_count = empty_count_q;
`endif

endmodule

// File: tb/tb_jtag_tx_arbiter.sv
// Self-checking bench for jtag_tx_arbiter: vector table, directed corner cases, random traffic vs. model.
module tb_jtag_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cap = 1'b0;
  logic [NREQ-1:0] vld = '0;
  logic [DW-1:0] pay [NREQ];
  logic [NREQ*DW-1:0] data_flat;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  jtag_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

`ifdef JTAG_ARB_STATS_EN
  logic [15:0] pop_count, empty_count;
`endif

  jtag_tx_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus)
`ifdef JTAG_ARB_STATS_EN
    ,
    .pop_count(pop_count),
    .empty_count(empty_count)
`endif
  );

  always_comb begin
    data_flat = '0;
    for (int i = 0; i < NREQ; i++) data_flat[i*DW +: DW] = pay[i];
  end
  assign bus.req_valid = vld;
  assign bus.req_data  = data_flat;
  assign bus.cap       = cap;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference model: host-visible state only.
  bit          m_held = 1'b0;
  logic [31:0] m_word = '0;
  int          m_ptr  = 0;
  int          m_pop  = 0;
  int          m_emp  = 0;
  int          last_xfer = -1;

  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (vld[j]) return j;
    end
    return -1;
  endfunction

  task automatic cycle(input string tag);
    int w;
    logic [NREQ-1:0] er;
    @(negedge clk);
    w  = (!rst && !m_held) ? pick() : -1;
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(er));
    chk({tag, ".tx"}, bus.tx_word, m_word);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(m_held));
`ifdef JTAG_ARB_STATS_EN
    chk({tag, ".pops"}, 32'(pop_count), 32'(m_pop));
    chk({tag, ".empties"}, 32'(empty_count), 32'(m_emp));
`endif
    if (rst) begin
      m_held = 1'b0; m_word = '0; m_ptr = 0; m_pop = 0; m_emp = 0;
    end else begin
      if (cap && m_held && m_pop < 65535) m_pop++;
      if (cap && !m_held && m_emp < 65535) m_emp++;
      if (m_held) begin
        if (cap) begin m_held = 1'b0; m_word = '0; end
      end else if (w >= 0) begin
        m_held = 1'b1;
        m_word = {1'b1, 3'(w), pay[w]};
        m_ptr  = (w + 1) % NREQ;
      end
    end
    @(posedge clk);
    #1;
    last_xfer = w;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic        cap;
    logic [3:0]  rdy;
    logic [31:0] tx;
    logic        busy;
  } vec_t;

  vec_t tbl [14];
  int   cnt [NREQ];
  logic [31:0] saved;

  initial begin
    tbl[0]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 32'h0000_0000, 1'b0};
    tbl[2]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 32'h0000_0000, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 32'hA0AB_CDEF, 1'b1};
    tbl[4]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 32'hA0AB_CDEF, 1'b1};
    tbl[5]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 32'h0000_0000, 1'b0};
    tbl[6]  = '{1'b0, 4'b0011, 1'b0, 4'b0001, 32'h0000_0000, 1'b0};
    tbl[7]  = '{1'b0, 4'b0010, 1'b0, 4'b0000, 32'h8111_1111, 1'b1};
    tbl[8]  = '{1'b0, 4'b0010, 1'b1, 4'b0000, 32'h8111_1111, 1'b1};
    tbl[9]  = '{1'b0, 4'b0010, 1'b0, 4'b0010, 32'h0000_0000, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 32'h9222_2222, 1'b1};
    tbl[11] = '{1'b0, 4'b1000, 1'b1, 4'b1000, 32'h0000_0000, 1'b0};
    tbl[12] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 32'hB333_3333, 1'b1};
    tbl[13] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 32'h0000_0000, 1'b0};

    pay[0] = 28'h111_1111;
    pay[1] = 28'h222_2222;
    pay[2] = 28'h0AB_CDEF;
    pay[3] = 28'h333_3333;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int r = 0; r < 14; r++) begin
`ifdef JTAG_ARB_STATS_EN
      if (r == 13) begin
        chk("tbl.pop_count", 32'(pop_count), 32'd4);
        chk("tbl.empty_count", 32'(empty_count), 32'd2);
      end
`endif
      rst = tbl[r].rst;
      vld = tbl[r].vld;
      cap = tbl[r].cap;
      @(negedge clk);
      chk($sformatf("tbl%0d.ready", r), 32'(bus.req_ready), 32'(tbl[r].rdy));
      chk($sformatf("tbl%0d.tx", r), bus.tx_word, tbl[r].tx);
      chk($sformatf("tbl%0d.busy", r), 32'(bus.busy), 32'(tbl[r].busy));
      @(posedge clk);
      #1;
    end
    rst = 1'b0; vld = '0; cap = 1'b0;

    // Fairness: all requesters continuously valid, eight pops.
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    vld = '1;
    for (int k = 0; k < 8; k++) begin
      cap = 1'b0;
      cycle("fair_grant");
      if (last_xfer >= 0) cnt[last_xfer]++;
      chk("fair.src", {29'b0, bus.tx_word[30:28]}, 32'(k % NREQ));
      cap = 1'b1;
      cycle("fair_pop");
      pay[(k % NREQ)] = DW'($urandom);
    end
    for (int i = 0; i < NREQ; i++) chk($sformatf("fair.count%0d", i), 32'(cnt[i]), 32'd2);
    cap = 1'b0; vld = '0;

    // Held word ignores a new requester until captured.
    rst = 1'b1; cycle("hold_rst"); rst = 1'b0;
    vld = 4'b0001;
    cycle("hold_grant");
    saved = bus.tx_word;
    vld = 4'b0010;
    for (int k = 0; k < 20; k++) cycle("hold_wait");
    chk("hold.tx_stable", bus.tx_word, saved);
    chk("hold.busy", 32'(bus.busy), 32'd1);

    // Reset while holding discards the word; lowest valid index wins next.
    rst = 1'b1;
    cycle("midrst");
    rst = 1'b0;
    vld = 4'b0110;
    cycle("midrst_grant");
    chk("midrst.src", {29'b0, bus.tx_word[30:28]}, 32'd1);
    vld = '0; cap = 1'b1;
    cycle("midrst_pop");
    cap = 1'b0;

    // Random traffic with requesters holding data stable until transfer.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      cap = ($urandom_range(0, 3) == 0);
      cycle("rand");
      for (int i = 0; i < NREQ; i++) begin
        if (last_xfer == i) begin
          vld[i] = $urandom_range(0, 1) == 1;
          pay[i] = DW'($urandom);
        end else if (!vld[i] && $urandom_range(0, 2) == 0) begin
          vld[i] = 1'b1;
          pay[i] = DW'($urandom);
        end
      end
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/jtag_tx_arbiter.md
# jtag_tx_arbiter

Round-robin arbiter that shares the single 32-bit JTAG POP (host-read) data path among up to eight on-chip requesters. It holds one tagged word at a time for the JTAG data-register capture, then consumes it and grants the next requester. The block sits in the `tck` domain, between the collision-detection result producers and the virtual-JTAG capture/shift logic.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 1..8.
- `DW`, 28: payload bits per requester word. Fixed at 28; the other 4 bits carry the header.

Ports:
- `clk`  in  1  JTAG `tck`.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  one bit per requester; word available.
- `req_data`  in  NREQ*DW  requester i payload in bits `[i*DW +: DW]`.
- `req_ready`  out  NREQ  one-hot grant; transfer when `req_valid[i] && req_ready[i]`.
- `cap`  in  1  one-cycle strobe, equal to capture-DR while the POP instruction is selected.
- `tx_word`  out  32  word loaded by the shift register on `cap`: `{full, src[2:0], payload[27:0]}`.
- `busy`  out  1  high while a word is held (state HOLD).
- `pop_count`  out  16  present only with `JTAG_ARB_STATS_EN`.
- `empty_count`  out  16  present only with `JTAG_ARB_STATS_EN`.

## Operation
- Two states: IDLE (nothing held) and HOLD (word held for the host).
- IDLE, combinational:
  - Search `req_valid` starting at pointer `ptr`, ascending, wrapping modulo NREQ.
  - The first set bit is the winner. Assert `req_ready[winner]` only; every other `req_ready` bit is 0.
  - With no valid requester, `req_ready` is all 0.
- IDLE, clock edge with a winner:
  - `tx_word <= {1'b1, winner[2:0], payload}`.
  - State goes to HOLD.
  - `ptr <= (winner+1) mod NREQ`.
- HOLD:
  - `req_ready` is all 0.
  - `tx_word` is stable.
  - When `cap` is sampled high: state goes to IDLE and `tx_word <= 32'h0000_0000`.
- `cap` in IDLE: the host captures the empty word 0x00000000. Arbitration on that same edge proceeds normally.
- Requester rule: `req_valid` and `req_data` must stay stable until the transfer. The arbiter never consumes a word unless `req_ready` is high.
- Unused requester slots: with NREQ < 8, `src` values ≥ NREQ never appear.
- Reset mid-HOLD: the held word is discarded. It is not retransmitted.
- Reset values:
  - `tx_word` = 0, `busy` = 0, `req_ready` = 0.
  - `ptr` = 0, state = IDLE.
  - Both counters = 0.

## Timing
- Grant latency: a `req_valid` that rises in IDLE with the highest priority gets `req_ready` in the same cycle. `tx_word` and `busy` update at the next edge.
- Capture: `cap` sampled at edge N returns the `tx_word` value present before edge N. The new value (zero, or the next word) appears after edge N.
- Back-to-back: at best one word per 2 cycles (HOLD→IDLE, then IDLE→HOLD). The host normally pops far slower.
- Simultaneous `cap` and a new valid in IDLE: the host gets the empty word, and the new word is latched on the same edge.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ grants.
- `ptr` advances only on a grant, never on `cap` alone.

## Configuration
- `JTAG_ARB_STATS_EN` defined:
  - `pop_count` increments on each `cap` sampled in HOLD.
  - `empty_count` increments on each `cap` sampled in IDLE.
  - Both counters saturate at 16'hFFFF and clear only on reset.
- `JTAG_ARB_STATS_EN` undefined:
  - Both ports and counters are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then pulse `cap` with no requests → `tx_word` = 0x00000000, `busy` = 0, `empty_count` = 1.
- Requester 2 valid with payload 0x0ABCDEF, then `cap` → `req_ready` = 0b0100 for one cycle; `tx_word` = 0xA0ABCDEF before `cap` and 0x00000000 after; `pop_count` = 1.
- All four requesters valid continuously, with 8 `cap` pulses → `src` sequence 0,1,2,3,0,1,2,3; each requester sees exactly 2 transfers.
- Word held, requester 1 asserts valid, no `cap` for 20 cycles → `req_ready` stays 0, `tx_word` unchanged, `busy` = 1.
- `reset` asserted while HOLD → next cycle `tx_word` = 0, `busy` = 0; the next grant goes to the lowest-index valid requester.
- `cap` and `req_valid[3]` rising in the same IDLE cycle → captured word 0x00000000; next `cap` returns `src` = 3.
